receptor_vga: RTL and testbench

Video-timing receiver and checker for the VGA output bus: consumes the hsync/vsync/n_blank/RGB stream that the VGA controller drives and recovers pixel coordinates. It verifies line and frame geometry, maintains a lock state, and produces a per-frame checksum of the active RGB data. It sits on the pixel-clock side of the bus, either as a self-check inside the FPGA design or as the capture front end of the verification environment.

---
 rtl/receptor_vga.sv | 229 ++++++++++++++++++++++
 tb/tb_receptor_vga.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/receptor_vga.sv
// receptor_vga: receiver and checker for the VGA output bus, clocked by the pixel clock.
// Recovers pixel coordinates from hsync/vsync/n_blank, checks line and frame geometry,
// keeps a lock state and builds a per-frame checksum of the active RGB data.
//
// Ports:
//   clock, reset          pixel clock; synchronous active-high reset
//   hsync, vsync          syncs, active low
//   n_blank               1 = active video
//   red, green, blue      pixel colour
//   pixel_x, pixel_y      coordinates of the current active pixel (with pixel_valido)
//   enganchado            lock achieved
//   error_sync            one-cycle pulse when lock is lost
//   checksum              sum of {red,green,blue} over the last complete frame
//   checksum_valido       one-cycle pulse when checksum updates
//   conteo_tramas         good frames seen while locked
module receptor_vga #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_ACTIVO    = 640,
  parameter int unsigned V_ACTIVO    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        n_blank,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valido,
  output logic        enganchado,
  output logic        error_sync,
  output logic [31:0] checksum,
  output logic        checksum_valido,
  output logic [15:0] conteo_tramas
);

  localparam int unsigned CW = 12;
  localparam logic [CW-1:0] CntMax     = {CW{1'b1}};
  localparam logic [CW-1:0] HTotal     = CW'(H_TOTAL);
  localparam logic [CW-1:0] VTotal     = CW'(V_TOTAL);
  localparam logic [CW-1:0] HActivo    = CW'(H_ACTIVO);
  localparam logic [CW-1:0] VActivo    = CW'(V_ACTIVO);
  localparam logic [15:0]   LockFrames = 16'(LOCK_FRAMES);

  typedef enum logic [1:0] {StBuscando, StSincronizando, StEnganchado} estado_e;

  estado_e        estado_q, estado_d;
  logic           hsync_s1_q, hsync_s1_d, hsync_s2_q, hsync_s2_d;
  logic           vsync_s1_q, vsync_s1_d, vsync_s2_q, vsync_s2_d;
  logic           blank_s1_q, blank_s1_d;
  logic [23:0]    rgb_s1_q, rgb_s1_d;
  logic [CW-1:0]  h_cont_q, h_cont_d;
  logic [9:0]     x_cont_q, x_cont_d;
  logic [9:0]     y_cont_q, y_cont_d;
  logic [CW-1:0]  lineas_q, lineas_d;
  logic [CW-1:0]  lineas_act_q, lineas_act_d;
  logic           trama_mala_q, trama_mala_d;
  logic           salto_q, salto_d;
  logic           inicio_ok_q, inicio_ok_d;
  logic [15:0]    buenas_q, buenas_d;
  logic [31:0]    acc_q, acc_d;
  logic [9:0]     pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic           pixel_valido_q, pixel_valido_d;
  logic           error_sync_q, error_sync_d;
  logic [31:0]    checksum_q, checksum_d;
  logic           checksum_valido_q, checksum_valido_d;
  logic [15:0]    conteo_q, conteo_d;

  logic           fin_linea, fin_trama, linea_activa, linea_mala, trama_buena, perdida;
  logic [9:0]     x_inc;
  logic [CW-1:0]  lineas_inc, act_inc;
  logic           mala_inc;
  logic [31:0]    acc_inc;

  always_comb begin
    hsync_s1_d = hsync;
    vsync_s1_d = vsync;
    blank_s1_d = n_blank;
    rgb_s1_d   = {red, green, blue};
    hsync_s2_d = hsync_s1_q;
    vsync_s2_d = vsync_s1_q;

    fin_linea = hsync_s2_q & ~hsync_s1_q;
    fin_trama = vsync_s2_q & ~vsync_s1_q;

    // Line bookkeeping includes the pixel sampled in the line-end cycle itself.
    x_inc        = (blank_s1_q && x_cont_q != 10'h3FF) ? x_cont_q + 10'd1 : x_cont_q;
    linea_activa = (x_inc != 10'd0);
    linea_mala   = fin_linea && ((!salto_q && (h_cont_q + 1'b1) != HTotal) ||
                                 ({2'b00, x_inc} > HActivo));

    // Line end is folded into the ending frame before the frame verdict is taken.
    lineas_inc  = (fin_linea && lineas_q != CntMax) ? lineas_q + 1'b1 : lineas_q;
    act_inc     = (fin_linea && linea_activa && lineas_act_q != CntMax) ?
                  lineas_act_q + 1'b1 : lineas_act_q;
    mala_inc    = trama_mala_q | linea_mala;
    trama_buena = !mala_inc && (lineas_inc == VTotal) && (act_inc == VActivo);
    acc_inc     = acc_q + (blank_s1_q ? {8'h00, rgb_s1_q} : 32'h0);

    h_cont_d = fin_linea ? '0 : ((h_cont_q == CntMax) ? CntMax : h_cont_q + 1'b1);
    x_cont_d = fin_linea ? 10'd0 : x_inc;

    y_cont_d = y_cont_q;
    if (fin_linea && linea_activa && y_cont_q != 10'h3FF) y_cont_d = y_cont_q + 10'd1;
    if (fin_trama) y_cont_d = 10'd0;

    lineas_d     = fin_trama ? '0 : lineas_inc;
    lineas_act_d = fin_trama ? '0 : act_inc;
    trama_mala_d = fin_trama ? 1'b0 : mala_inc;
    acc_d        = fin_trama ? 32'h0 : acc_inc;

    // Lock state machine.
    estado_d = estado_q;
    buenas_d = buenas_q;
    conteo_d = conteo_q;
    perdida  = linea_mala && (estado_q == StEnganchado);
    if (fin_trama) begin
      unique case (estado_q)
        StBuscando: begin
          estado_d = StSincronizando;
          buenas_d = 16'd0;
        end
        StSincronizando: begin
          if (!trama_buena) begin
            buenas_d = 16'd0;
          end else if (buenas_q + 16'd1 >= LockFrames) begin
            estado_d = StEnganchado;
            buenas_d = 16'd0;
          end else begin
            buenas_d = buenas_q + 16'd1;
          end
        end
        StEnganchado: begin
          if (trama_buena) conteo_d = conteo_q + 16'd1;
          else             perdida  = 1'b1;
        end
        default: estado_d = StBuscando;
      endcase
    end
    if (perdida) estado_d = StBuscando;
    error_sync_d = perdida;

    // Right after leaving BUSCANDO the line timing reference is unknown, so skip one check.
    salto_d = salto_q;
    if (fin_linea) salto_d = 1'b0;
    if (fin_trama && estado_q == StBuscando) salto_d = 1'b1;

    // A checksum is only published for frames that started outside BUSCANDO.
    inicio_ok_d       = fin_trama ? (estado_d != StBuscando) : inicio_ok_q;
    checksum_d        = checksum_q;
    checksum_valido_d = 1'b0;
    if (fin_trama && inicio_ok_q) begin
      checksum_d        = acc_inc;
      checksum_valido_d = 1'b1;
    end

    pixel_valido_d = blank_s1_q;
    pixel_x_d      = blank_s1_q ? x_cont_q : 10'd0;
    pixel_y_d      = blank_s1_q ? y_cont_q : 10'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q          <= StBuscando;
      hsync_s1_q        <= 1'b0;
      hsync_s2_q        <= 1'b0;
      vsync_s1_q        <= 1'b0;
      vsync_s2_q        <= 1'b0;
      blank_s1_q        <= 1'b0;
      rgb_s1_q          <= 24'h0;
      h_cont_q          <= '0;
      x_cont_q          <= 10'd0;
      y_cont_q          <= 10'd0;
      lineas_q          <= '0;
      lineas_act_q      <= '0;
      trama_mala_q      <= 1'b0;
      salto_q           <= 1'b0;
      inicio_ok_q       <= 1'b0;
      buenas_q          <= 16'd0;
      acc_q             <= 32'h0;
      pixel_x_q         <= 10'd0;
      pixel_y_q         <= 10'd0;
      pixel_valido_q    <= 1'b0;
      error_sync_q      <= 1'b0;
      checksum_q        <= 32'h0;
      checksum_valido_q <= 1'b0;
      conteo_q          <= 16'd0;
    end else begin
      estado_q          <= estado_d;
      hsync_s1_q        <= hsync_s1_d;
      hsync_s2_q        <= hsync_s2_d;
      vsync_s1_q        <= vsync_s1_d;
      vsync_s2_q        <= vsync_s2_d;
      blank_s1_q        <= blank_s1_d;
      rgb_s1_q          <= rgb_s1_d;
      h_cont_q          <= h_cont_d;
      x_cont_q          <= x_cont_d;
      y_cont_q          <= y_cont_d;
      lineas_q          <= lineas_d;
      lineas_act_q      <= lineas_act_d;
      trama_mala_q      <= trama_mala_d;
      salto_q           <= salto_d;
      inicio_ok_q       <= inicio_ok_d;
      buenas_q          <= buenas_d;
      acc_q             <= acc_d;
      pixel_x_q         <= pixel_x_d;
      pixel_y_q         <= pixel_y_d;
      pixel_valido_q    <= pixel_valido_d;
      error_sync_q      <= error_sync_d;
      checksum_q        <= checksum_d;
      checksum_valido_q <= checksum_valido_d;
      conteo_q          <= conteo_d;
    end
  end

  assign pixel_x         = pixel_x_q;
  assign pixel_y         = pixel_y_q;
  assign pixel_valido    = pixel_valido_q;
  assign enganchado      = (estado_q == StEnganchado);
  assign error_sync      = error_sync_q;
  assign checksum        = checksum_q;
  assign checksum_valido = checksum_valido_q;
  assign conteo_tramas   = conteo_q;

endmodule

// File: tb/tb_receptor_vga.sv
// tb_receptor_vga: drives a reduced-geometry VGA stream (20x12 total, 12x8 active) into
// receptor_vga. Expected pixel coordinates and frame checksums are queued as the stream
// is driven and compared when the DUT presents them; lock state and frame count are
// compared after every frame against the expected value for that point in the sequence.
module tb_receptor_vga;

  localparam int HT = 20;
  localparam int VT = 12;
  localparam int HA = 12;
  localparam int VA = 8;
  localparam int HS_W = 2;
  localparam int ACT_C0 = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        n_blank = 1'b0;
  logic [7:0]  red = 8'h0, green = 8'h0, blue = 8'h0;
  logic [9:0]  pixel_x, pixel_y;
  logic        pixel_valido, enganchado, error_sync, checksum_valido;
  logic [31:0] checksum;
  logic [15:0] conteo_tramas;

  receptor_vga #(
    .H_TOTAL    (HT),
    .V_TOTAL    (VT),
    .H_ACTIVO   (HA),
    .V_ACTIVO   (VA),
    .LOCK_FRAMES(2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .hsync          (hsync),
    .vsync          (vsync),
    .n_blank        (n_blank),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .pixel_valido   (pixel_valido),
    .enganchado     (enganchado),
    .error_sync     (error_sync),
    .checksum       (checksum),
    .checksum_valido(checksum_valido),
    .conteo_tramas  (conteo_tramas)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          err_at = -100;
  int          err_cnt = 0;
  logic [19:0] pix_q[$];
  logic [31:0] cks_q[$];
  logic [19:0] exp_pix;
  logic [31:0] exp_cks;
  logic [31:0] suma_prev = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: pops the scoreboards whenever the DUT presents data.
  always @(negedge clock) begin
    if (pixel_valido) begin
      if (pix_q.size() == 0) begin
        check_eq("pixel_unexpected", 32'(pixel_valido), 32'd0);
      end else begin
        exp_pix = pix_q.pop_front();
        check_eq("pixel_x", 32'(pixel_x), 32'(exp_pix[19:10]));
        check_eq("pixel_y", 32'(pixel_y), 32'(exp_pix[9:0]));
      end
    end
    if (checksum_valido) begin
      if (cks_q.size() == 0) begin
        check_eq("checksum_unexpected", 32'(checksum_valido), 32'd0);
      end else begin
        exp_cks = cks_q.pop_front();
        check_eq("checksum", checksum, exp_cks);
      end
    end
    if (error_sync) err_cnt++;
    if (cyc == err_at - 1) check_eq("lock_before_err", 32'(enganchado), 32'd1);
    if (cyc == err_at) begin
      check_eq("error_sync_pulse", 32'(error_sync), 32'd1);
      check_eq("lock_after_err", 32'(enganchado), 32'd0);
    end
  end

  // modo: 0 black, 1 white, 2 only pixel (0,0) red, 3 random colours.
  task automatic drive_frame(input int act_start, input int n_act, input int bad_line,
                             input int vs_off, input int modo, input bit cks_due,
                             input bit exp_err, input int n_lines);
    logic [31:0] suma;
    logic [23:0] rgb;
    int          len;
    bit          act;
    bit          vs;
    suma = 32'h0;
    for (int l = 0; l < n_lines; l++) begin
      len = (l == bad_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        act = (l >= act_start) && (l < act_start + n_act) && (c >= ACT_C0) && (c < ACT_C0 + HA);
        vs  = !((l == 0 && c >= vs_off) || l == 1);
        rgb = 24'h0;
        if (act) begin
          case (modo)
            1:       rgb = 24'hFFFFFF;
            2:       rgb = (l == act_start && c == ACT_C0) ? 24'hFF0000 : 24'h0;
            3:       rgb = 24'($urandom);
            default: rgb = 24'h0;
          endcase
        end
        @(negedge clock);
        if (l == 0 && c == vs_off && cks_due) cks_q.push_back(suma_prev);
        if (exp_err && l == bad_line + 1 && c == 0) err_at = cyc + 2;
        hsync   = (c >= HS_W);
        vsync   = vs;
        n_blank = act;
        {red, green, blue} = rgb;
        if (act) begin
          pix_q.push_back({10'(c - ACT_C0), 10'(l - act_start)});
          suma = suma + {8'h00, rgb};
        end
      end
    end
    suma_prev = suma;
  endtask

  task automatic trama(input int act_start, input int n_act, input int bad_line,
                       input int vs_off, input int modo, input bit cks_due, input bit exp_err,
                       input bit exp_lock, input int exp_conteo);
    drive_frame(act_start, n_act, bad_line, vs_off, modo, cks_due, exp_err, VT);
    check_eq("enganchado", 32'(enganchado), 32'(exp_lock));
    check_eq("conteo_tramas", 32'(conteo_tramas), 32'(exp_conteo));
  endtask

  task automatic do_reset(input int ciclos);
    @(negedge clock);
    reset   = 1'b1;
    hsync   = 1'b1;
    vsync   = 1'b1;
    n_blank = 1'b0;
    {red, green, blue} = 24'h0;
    @(negedge clock);
    check_eq("rst_pixel_x", 32'(pixel_x), 32'd0);
    check_eq("rst_pixel_y", 32'(pixel_y), 32'd0);
    check_eq("rst_pixel_valido", 32'(pixel_valido), 32'd0);
    check_eq("rst_enganchado", 32'(enganchado), 32'd0);
    check_eq("rst_error_sync", 32'(error_sync), 32'd0);
    check_eq("rst_checksum", checksum, 32'd0);
    check_eq("rst_checksum_valido", 32'(checksum_valido), 32'd0);
    check_eq("rst_conteo", 32'(conteo_tramas), 32'd0);
    repeat (ciclos) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    do_reset(3);
    // Nominal black stream: lock at the 3rd vsync fall, then one count per frame.
    trama(2, VA, -1, 2, 0, 1'b0, 1'b0, 1'b0, 0);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b0, 0);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b1, 0);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b1, 1);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b1, 2);
    // Colour patterns: white, single red pixel, random.
    trama(2, VA, -1, 2, 1, 1'b1, 1'b0, 1'b1, 3);
    trama(2, VA, -1, 2, 2, 1'b1, 1'b0, 1'b1, 4);
    trama(2, VA, -1, 2, 3, 1'b1, 1'b0, 1'b1, 5);
    trama(2, VA, -1, 2, 3, 1'b1, 1'b0, 1'b1, 6);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b1, 7);
    check_eq("no_error_sync_nominal", 32'(err_cnt), 32'd0);
    // Short line while locked: loss of lock, then relock after three vsync falls.
    trama(2, VA, 5, 2, 0, 1'b1, 1'b1, 1'b0, 8);
    check_eq("error_sync_count", 32'(err_cnt), 32'd1);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b0, 8);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b0, 8);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b1, 8);
    trama(2, VA, -1, 2, 3, 1'b1, 1'b0, 1'b1, 9);
    // Reset in the middle of a locked frame.
    drive_frame(2, VA, -1, 2, 3, 1'b1, 1'b0, 6);
    do_reset(2);
    // First synchronising frame is one active line short: lock delayed by a frame.
    trama(2, VA - 1, -1, 2, 3, 1'b0, 1'b0, 1'b0, 0);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b0, 0);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b0, 0);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b1, 0);
    // Active lines at the end of the frame, with hsync and vsync falling together.
    trama(4, VA, -1, 2, 3, 1'b1, 1'b0, 1'b1, 1);
    trama(4, VA, -1, 0, 3, 1'b1, 1'b0, 1'b1, 2);
    trama(4, VA, -1, 0, 0, 1'b1, 1'b0, 1'b1, 3);
    trama(2, VA, -1, 2, 0, 1'b1, 1'b0, 1'b1, 4);
    repeat (5) @(negedge clock);
    check_eq("error_sync_total", 32'(err_cnt), 32'd1);
    check_eq("pixels_pending", 32'(pix_q.size()), 32'd0);
    check_eq("checksums_pending", 32'(cks_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
